m90_irq_ctrl: RTL and testbench

Interrupt controller for the M90 main CPU. It sits between the video timing outputs (`vblank`, `hint` from the GA25) and the V33 core's interrupt request and acknowledge pins, and feeds the top-level `int_req`/`int_vector` nets. It performs:
- rising-edge capture of up to three interrupt sources
- per-source masking and fixed priority
- in-service tracking with end-of-interrupt (EOI)
- sequencing of the V33 two-pulse INTAK acknowledge, so the vector stays stable for the whole acknowledge.

---
 rtl/m90_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_m90_irq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m90_irq_ctrl.sv
// M90 interrupt controller: edge-captured sources, mask, fixed priority, in-service/EOI, V33 two-pulse INTAK sequencing.
// Optional build macro M90_IRQ_AUTO_EOI_EN: in-service tracking disabled, EOI ignored, no nesting restriction.
module m90_irq_ctrl #(
  parameter logic [7:0] VECTOR_BASE = 8'h60,
  parameter logic [7:0] IO_BASE     = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  src,
  input  logic        intak,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [7:0]  io_addr,
  input  logic [15:0] io_din,
  output logic [15:0] io_dout,
  output logic        int_req,
  output logic [7:0]  int_vector
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_ACK2 = 2'd3;

  localparam logic [7:0] ADDR_CTRL = IO_BASE;
  localparam logic [7:0] ADDR_PCLR = IO_BASE + 8'd4;
`ifndef M90_IRQ_AUTO_EOI_EN
  localparam logic [7:0] ADDR_EOI  = IO_BASE + 8'd2;
`endif

  logic [1:0] state, state_next;
  logic [2:0] src_q, intak_q_unused_pad;
  logic       io_wr_q, intak_q;
  logic [2:0] pending, in_service, mask;

  logic [2:0] src_rise, allow, eligible, grant, pclr;
  logic [2:0] pending_next, in_service_next;
  logic [2:0] sel_next;
  logic       wr_pulse, intak_rise, spurious, ack_take;
  logic       unused_io_din;

  assign intak_q_unused_pad = 3'b000;
  assign unused_io_din      = ^{io_din[15:3], intak_q_unused_pad};

  assign src_rise   = src & ~src_q;
  assign wr_pulse   = io_wr & ~io_wr_q;
  assign intak_rise = intak & ~intak_q;

  // Nesting: only sources strictly above the highest-priority source in service may interrupt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    allow = 3'b111;
`ifndef M90_IRQ_AUTO_EOI_EN
    if (in_service[0])      allow = 3'b000;
    else if (in_service[1]) allow = 3'b001;
    else if (in_service[2]) allow = 3'b011;
`endif
  end

  assign eligible = pending & mask & allow;
  assign spurious = ~|eligible;

  always_comb begin
    sel_next = 3'd7;
    if (eligible[0])      sel_next = 3'd0;
    else if (eligible[1]) sel_next = 3'd1;
    else if (eligible[2]) sel_next = 3'd2;
  end

  assign ack_take = (state == ST_IDLE) && intak_rise;
  assign grant    = (ack_take && !spurious) ? (3'b001 << sel_next) : 3'b000;
  assign pclr     = (wr_pulse && io_addr == ADDR_PCLR) ? io_din[2:0] : 3'b000;

  // A new source edge outranks any clear arriving on the same edge.
  assign pending_next = (pending & ~pclr & ~grant) | src_rise;

`ifdef M90_IRQ_AUTO_EOI_EN
  assign in_service_next = 3'b000;
`else
  logic [2:0] eoi_clr;
  assign eoi_clr = (wr_pulse && io_addr == ADDR_EOI) ? (in_service & (~in_service + 3'd1)) : 3'b000;
  assign in_service_next = (in_service & ~eoi_clr) | grant;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (intak_rise) state_next = ST_ACK1;
      ST_ACK1: if (!intak)     state_next = ST_GAP;
      ST_GAP:  if (intak_rise) state_next = ST_ACK2;
      ST_ACK2: if (!intak)     state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      src_q      <= 3'b000;
      io_wr_q    <= 1'b0;
      intak_q    <= 1'b0;
      pending    <= 3'b000;
      in_service <= 3'b000;
      mask       <= 3'b000;
      int_req    <= 1'b0;
      int_vector <= 8'h00;
    end else begin
      state      <= state_next;
      src_q      <= src;
      io_wr_q    <= io_wr;
      intak_q    <= intak;
      pending    <= pending_next;
      in_service <= in_service_next;
      if (wr_pulse && io_addr == ADDR_CTRL) mask <= io_din[2:0];
      int_req    <= (state == ST_IDLE) && !spurious;
      // Vector is frozen for the whole acknowledge so the second INTAK pulse sees the same value.
      if (ack_take)
        int_vector <= VECTOR_BASE + {5'd0, sel_next};
      else if (state_next == ST_IDLE)
        int_vector <= 8'h00;
    end
  end

  always_comb begin
    io_dout = 16'hffff;
    if (io_rd && io_addr == ADDR_CTRL)
      io_dout = {7'd0, in_service, pending, mask};
  end

endmodule

// File: tb/tb_m90_irq_ctrl.sv
// Self-checking bench for m90_irq_ctrl: directed boundary cases plus random traffic against a behavioural model.
module tb_m90_irq_ctrl;

  localparam logic [7:0] VB = 8'h60;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src;
  logic        intak, io_wr, io_rd;
  logic [7:0]  io_addr;
  logic [15:0] io_din, io_dout;
  logic        int_req;
  logic [7:0]  int_vector;

  m90_irq_ctrl #(.VECTOR_BASE(8'h60), .IO_BASE(8'h40)) dut (
    .clk(clk), .reset(reset), .src(src), .intak(intak),
    .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_din(io_din),
    .io_dout(io_dout), .int_req(int_req), .int_vector(int_vector)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Behavioural model state, one bit per source.
  bit [2:0] m_pend, m_insvc, m_mask;

  logic [7:0]  exp_vec_q[$];
  logic [15:0] exp_rd_q[$];
  logic        vec_strobe = 1'b0;
  logic        rd_strobe  = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations whenever the driver flags a valid sample.
  always @(negedge clk) begin
    if (vec_strobe) begin
      if (exp_vec_q.size() == 0) check("vec_underflow", 16'd1, 16'd0);
      else check("int_vector", {8'h00, int_vector}, {8'h00, exp_vec_q.pop_front()});
    end
    if (rd_strobe) begin
      if (exp_rd_q.size() == 0) check("rd_underflow", 16'd1, 16'd0);
      else check("io_dout", io_dout, exp_rd_q.pop_front());
    end
  end

  function automatic int model_sel();
    int limit = 3;
`ifndef M90_IRQ_AUTO_EOI_EN
    for (int i = 0; i < 3; i++) if (m_insvc[i]) begin limit = i; break; end
`endif
    for (int i = 0; i < limit; i++) if (m_pend[i] && m_mask[i]) return i;
    return 7;
  endfunction

  function automatic logic [7:0] model_ack();
    int s = model_sel();
    if (s != 7) begin
      m_pend[s] = 1'b0;
`ifndef M90_IRQ_AUTO_EOI_EN
      m_insvc[s] = 1'b1;
`endif
    end
    return VB + 8'(s);
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
    if (a == 8'h40) m_mask = d[2:0];
    else if (a == 8'h44) m_pend = m_pend & ~d[2:0];
`ifndef M90_IRQ_AUTO_EOI_EN
    else if (a == 8'h42) begin
      for (int i = 0; i < 3; i++) if (m_insvc[i]) begin m_insvc[i] = 1'b0; break; end
    end
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [7:0] a);
    if (a == 8'h40) return {7'd0, m_insvc, m_pend, m_mask};
    return 16'hffff;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_din = d;
    tick();
    io_wr = 1'b0;
    tick();
    model_write(a, d);
  endtask

  task automatic io_read(input logic [7:0] a);
    exp_rd_q.push_back(model_read(a));
    io_rd = 1'b1; io_addr = a; rd_strobe = 1'b1;
    tick();
    io_rd = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic pulse_src(input int idx);
    src[idx] = 1'b1;
    tick();
    src[idx] = 1'b0;
    tick();
    m_pend[idx] = 1'b1;
  endtask

  // Full two-pulse acknowledge; optionally fires a source edge during the gap.
  task automatic do_ack(input int gap_src);
    logic [7:0] v;
    v = model_ack();
    exp_vec_q.push_back(v);
    exp_vec_q.push_back(v);
    intak = 1'b1;
    tick();
    vec_strobe = 1'b1;
    tick();
    vec_strobe = 1'b0; intak = 1'b0;
    tick();
    if (gap_src >= 0) src[gap_src] = 1'b1;
    tick();
    if (gap_src >= 0) begin src[gap_src] = 1'b0; m_pend[gap_src] = 1'b1; end
    intak = 1'b1;
    tick();
    vec_strobe = 1'b1;
    tick();
    vec_strobe = 1'b0; intak = 1'b0;
    tick();
    check("vec_idle", {8'h00, int_vector}, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    reset = 1'b1; src = 3'b000; intak = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    io_addr = 8'h00; io_din = 16'h0000;
    m_pend = '0; m_insvc = '0; m_mask = '0;
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_int_req", {15'd0, int_req}, 16'd0);
    check("rst_vector", {8'h00, int_vector}, 16'h0000);
    check("dout_unread", io_dout, 16'hffff);
    io_read(8'h40);

    // Latency: pending one edge after the source edge is sampled, int_req one edge later.
    io_write(8'h40, 16'h0003);
    src[0] = 1'b1;
    tick();
    check("lat_req_early", {15'd0, int_req}, 16'd0);
    tick();
    check("lat_req_high", {15'd0, int_req}, 16'd1);
    src[0] = 1'b0;
    m_pend[0] = 1'b1;
    tick();
    io_read(8'h40);
    do_ack(-1);
    io_read(8'h40);
    check("req_after_ack", {15'd0, int_req}, 16'd0);

    // Held write strobe: only the first cycle's data lands.
    io_wr = 1'b1; io_addr = 8'h40; io_din = 16'h0001;
    tick();
    io_din = 16'h0007;
    tick(2);
    io_wr = 1'b0;
    tick();
    m_mask = 3'b001;
    io_read(8'h40);
    io_write(8'h40, 16'h0003);

`ifndef M90_IRQ_AUTO_EOI_EN
    io_write(8'h42, 16'h0000);
    src = 3'b011;
    tick();
    src = 3'b000;
    tick();
    m_pend = m_pend | 3'b011;
    do_ack(-1);
    tick(2);
    check("req_blocked", {15'd0, int_req}, 16'd0);
    io_write(8'h42, 16'h0000);
    check("req_after_eoi", {15'd0, int_req}, 16'd1);
    do_ack(-1);
    io_read(8'h40);
    // Nested service of source 0 over source 1.
    pulse_src(0);
    do_ack(-1);
    io_read(8'h40);
    io_write(8'h42, 16'h0000);
    io_read(8'h40);
    io_write(8'h42, 16'h0000);
`else
    for (int k = 0; k < 3; k++) begin
      pulse_src(1);
      do_ack(-1);
      io_read(8'h40);
    end
`endif

    // Pending-clear colliding with a fresh edge on the same bit: the edge wins.
    pulse_src(0);
    src[0] = 1'b1; io_wr = 1'b1; io_addr = 8'h44; io_din = 16'h0001;
    tick();
    src[0] = 1'b0; io_wr = 1'b0;
    tick();
    io_read(8'h40);
    io_write(8'h40, 16'h0000);
    do_ack(-1);
    io_read(8'h40);
    io_write(8'h44, 16'h0007);
    io_write(8'h40, 16'h0007);
    pulse_src(2);
    do_ack(1);
    io_read(8'h40);

    // Random traffic.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0: pulse_src(int'($urandom_range(0, 2)));
        1: io_write(8'h40, 16'($urandom_range(0, 16'hffff)));
        2: io_write(8'h42, 16'($urandom_range(0, 16'hffff)));
        3: io_write(8'h44, 16'($urandom_range(0, 7)));
        4: do_ack(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
        default: begin
          case ($urandom_range(0, 3))
            0: io_read(8'h40);
            1: io_read(8'h42);
            2: io_read(8'h44);
            default: io_read(8'h41);
          endcase
        end
      endcase
    end
    io_read(8'h40);

    // Reset in the gap between INTAK pulses.
    io_write(8'h40, 16'h0002);
    pulse_src(1);
    v = model_ack();
    intak = 1'b1;
    tick(2);
    intak = 1'b0;
    tick();
    check("gap_vector", {8'h00, int_vector}, {8'h00, v});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pend = '0; m_insvc = '0; m_mask = '0;
    check("rst_gap_req", {15'd0, int_req}, 16'd0);
    check("rst_gap_vector", {8'h00, int_vector}, 16'h0000);
    io_read(8'h40);
    io_write(8'h40, 16'h0002);
    pulse_src(1);
    do_ack(-1);
    io_read(8'h40);

    tick(2);
    check("vec_q_empty", 16'(exp_vec_q.size()), 16'd0);
    check("rd_q_empty", 16'(exp_rd_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
